// File: rtl/param_stream_mux.sv
// param_stream_mux
//   Selects one of N valid/ready input channels and drives a single
//   registered output stream. Two run-time modes:
//     mode = 0 : direct select, sel picks the channel
//     mode = 1 : round-robin arbitration among valid channels
//   A single output register with pass-through ready gives one cycle of
//   latency and full throughput while the consumer keeps draining.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mode       0 = direct select, 1 = round-robin
//   sel        channel index used in mode 0 (indices >= N never grant)
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered output data
//   out_ch     index of the channel that supplied out_data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
//   beat_cnt   input beats accepted since reset, wraps at 2^CNT_W
module param_stream_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     beat_cnt
);

  // Size of the index space reachable by sel; may exceed N when N is not
  // a power of two.
  localparam int SEL_SPAN = 1 << SEL_W;

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q,   out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0]    rr_ptr_q,   rr_ptr_d;

  logic [SEL_SPAN-1:0] valid_pad;
  logic                sel_ok;
  logic [SEL_W-1:0]    rr_ch;
  logic                rr_found;
  logic                load_en;
  logic                grant_ok;
  logic [SEL_W-1:0]    grant_ch;
  logic [WIDTH-1:0]    grant_data;

  // Zero-extend in_valid to the full sel range so an out-of-range sel
  // simply reads a 0 instead of indexing past the vector.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    valid_pad          = '0;
    valid_pad[N-1:0]   = in_valid;
  end

  assign sel_ok = valid_pad[sel];

  // Round-robin search in two passes: first the channels at or above the
  // pointer, then wrap to the channels below it. The first hit wins.
  always_comb begin
    rr_ch    = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!rr_found && in_valid[i] && (int'(rr_ptr_q) <= i)) begin
        rr_ch    = SEL_W'(i);
        rr_found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rr_found && in_valid[i]) begin
        rr_ch    = SEL_W'(i);
        rr_found = 1'b1;
      end
    end
  end

  // The output register can take a new beat when it is empty or being
  // drained this cycle.
  assign load_en  = !out_valid_q || out_ready;
  assign grant_ok = mode ? (|in_valid) : sel_ok;
  assign grant_ch = mode ? rr_ch : sel;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_ch == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is withheld during reset so no producer believes a beat was
  // taken on a cycle where reset discards it.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && load_en && grant_ok && (grant_ch == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    beat_cnt_d  = beat_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      // With no grant the register empties; data and channel keep their
      // last values so the output never carries an unknown.
      out_valid_d = grant_ok;
      if (grant_ok) begin
        out_data_d = grant_data;
        out_ch_d   = grant_ch;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        // The pointer only moves on round-robin grants; direct-select
        // traffic leaves the rotation where it was.
        if (mode) begin
          rr_ptr_d = (grant_ch == SEL_W'(N - 1)) ? '0 : grant_ch + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_param_stream_mux.sv
// Testbench for param_stream_mux (N=4, WIDTH=8). A behavioural model of
// the output register, beat counter and round-robin pointer is advanced
// alongside the DUT; scenario tasks compare DUT outputs against it.
module tb_param_stream_mux;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;
  localparam int VW    = 1 + SEL_W + WIDTH + CNT_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_W-1:0]     beat_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  bit              m_valid = 1'b0;
  logic [7:0]      m_data  = '0;
  int              m_ch    = 0;
  logic [15:0]     m_cnt   = '0;
  int              m_ptr   = 0;
  logic [N-1:0]    exp_ready;
  logic [N-1:0]    act_ready;

  logic [7:0] chan_ref [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  param_stream_mux #(
    .WIDTH (WIDTH),
    .N     (N),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic logic [VW-1:0] dut_vec();
    return {out_valid, out_ch, out_data, beat_cnt};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_valid, SEL_W'(m_ch), m_data, m_cnt};
  endfunction

  task automatic set_ref_data();
    in_data = {chan_ref[3], chan_ref[2], chan_ref[1], chan_ref[0]};
  endtask

  // Inputs are driven at the falling edge. This samples in_ready and works
  // out the expected ready from the rules, crosses one rising edge,
  // advances the model and returns at the next falling edge.
  task automatic tick();
    int  g;
    bit  ok;
    bit  load;
    #1;
    act_ready = in_ready;
    load = !m_valid || out_ready;
    ok = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin
        ok = 1'b1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (!ok && in_valid[c]) begin
          ok = 1'b1;
          g  = c;
        end
      end
    end
    exp_ready = (!rst && load && ok) ? (4'b0001 << g) : 4'b0000;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_cnt   = '0;
      m_ptr   = 0;
    end else if (load) begin
      m_valid = ok;
      if (ok) begin
        m_data = in_data[g*WIDTH +: WIDTH];
        m_ch   = g;
        m_cnt  = m_cnt + 16'd1;
        if (mode) m_ptr = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1; in_valid = '1;
    set_ref_data();
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (act_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_in_ready: got %b want 0000", act_ready);
      end
      vectors++;
      if ({out_valid, beat_cnt} !== {1'b0, 16'd0}) begin
        miscompares++;
        $display("FAIL reset_state: got valid=%b cnt=%0d want valid=0 cnt=0", out_valid, beat_cnt);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({out_valid, out_ch, out_data, beat_cnt} !== {1'b1, 2'd0, 8'h10, 16'd1}) begin
      miscompares++;
      $display("FAIL reset_first_beat: got v=%b ch=%0d d=%h cnt=%0d want v=1 ch=0 d=10 cnt=1",
               out_valid, out_ch, out_data, beat_cnt);
    end
  endtask

  task automatic test_mode0_sweep();
    mode = 1'b0; out_ready = 1'b1; in_valid = '1;
    set_ref_data();
    for (int s = 0; s < N; s++) begin
      sel = SEL_W'(s);
      for (int c = 0; c < 10; c++) begin
        tick();
        vectors++;
        if (act_ready !== exp_ready) begin
          miscompares++;
          $display("FAIL sweep_ready sel=%0d: got %b want %b", s, act_ready, exp_ready);
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
          miscompares++;
          $display("FAIL sweep_out sel=%0d: got %h want %h", s, dut_vec(), model_vec());
        end
        if (c == 0) begin
          vectors++;
          if ({out_ch, out_data} !== {SEL_W'(s), chan_ref[s]}) begin
            miscompares++;
            $display("FAIL sweep_select sel=%0d: got ch=%0d d=%h want ch=%0d d=%h",
                     s, out_ch, out_data, s, chan_ref[s]);
          end
        end
      end
    end
  endtask

  task automatic test_mode0_invalid();
    mode = 1'b0; out_ready = 1'b1; sel = 2'd2; in_valid = 4'b1011;
    tick();
    vectors++;
    if ({act_ready, out_valid} !== {4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL invalid_sel: got ready=%b valid=%b want ready=0000 valid=0", act_ready, out_valid);
    end
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL invalid_hold: got %h want %h", dut_vec(), model_vec());
    end
    in_valid = 4'b1111;
    tick();
    vectors++;
    if ({act_ready, out_valid, out_ch, out_data} !== {4'b0100, 1'b1, 2'd2, 8'h32}) begin
      miscompares++;
      $display("FAIL invalid_recover: got ready=%b v=%b ch=%0d d=%h want ready=0100 v=1 ch=2 d=32",
               act_ready, out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; in_valid = '0;
    tick();
    rst = 1'b0; mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    set_ref_data();
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (out_ch !== SEL_W'(i % N) || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL rr_all beat %0d: got ch=%0d vec=%h want ch=%0d vec=%h",
                 i, out_ch, dut_vec(), i % N, model_vec());
      end
    end
    vectors++;
    if (beat_cnt !== 16'd8) begin
      miscompares++;
      $display("FAIL rr_count: got %0d want 8", beat_cnt);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (out_ch !== ((i % 2 == 0) ? 2'd1 : 2'd3) || act_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rr_alt beat %0d: got ch=%0d ready=%b want ch=%0d ready=%b",
                 i, out_ch, act_ready, (i % 2 == 0) ? 1 : 3, exp_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [SEL_W+WIDTH+CNT_W-1:0] held;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = $urandom();
    tick();
    held = {out_ch, out_data, beat_cnt};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom();
      tick();
      vectors++;
      if ({act_ready, out_valid, out_ch, out_data, beat_cnt} !== {4'b0000, 1'b1, held}) begin
        miscompares++;
        $display("FAIL bp_stall %0d: got ready=%b v=%b rest=%h want ready=0000 v=1 rest=%h",
                 i, act_ready, out_valid, {out_ch, out_data, beat_cnt}, held);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_data = $urandom();
      tick();
      vectors++;
      if (out_ch !== SEL_W'((int'(held[SEL_W+WIDTH+CNT_W-1 -: SEL_W]) + k) % N) ||
          dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL bp_resume %0d: got ch=%0d vec=%h want ch=%0d vec=%h", k, out_ch, dut_vec(),
                 (int'(held[SEL_W+WIDTH+CNT_W-1 -: SEL_W]) + k) % N, model_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_held: got valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({out_valid, beat_cnt, act_ready} !== {1'b0, 16'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b cnt=%0d ready=%b want v=0 cnt=0 ready=0000",
               out_valid, beat_cnt, act_ready);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (out_ch !== SEL_W'(k) || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL mid_restart %0d: got ch=%0d vec=%h want ch=%0d vec=%h",
                 k, out_ch, dut_vec(), k, model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 1) != 0;
      sel       = SEL_W'($urandom_range(0, N - 1));
      in_valid  = N'($urandom());
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      vectors++;
      if (act_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rand_ready %0d: got %b want %b", i, act_ready, exp_ready);
      end
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL rand_out %0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_mode0_sweep();
    test_mode0_invalid();
    test_round_robin();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
